// File: rtl/frame_strobe_ctrl.sv
// rtl/frame_strobe_ctrl.sv - per-column configuration frame loader driving FrameData and a one-hot FrameStrobe pulse
//
// Ports:
//   UserCLK      configuration/fabric clock, rising edge
//   resetn       asynchronous active-low reset
//   s_data       stream word (header or row data)
//   s_valid      s_data valid
//   s_ready      word accepted when s_valid & s_ready at UserCLK rise
//   FrameData    row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  one-hot strobe for the addressed frame, otherwise zero
//   busy         high while loading rows or strobing
//   err          sticky bad-header flag, cleared only by reset
module frame_strobe_ctrl #(
    parameter int MaxFramesPerCol = 36,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 16,
    parameter int ColumnIndex     = 0,
    parameter int StrobeCycles    = 2
) (
    input  logic                                 UserCLK,
    input  logic                                 resetn,
    input  logic [FrameBitsPerRow-1:0]           s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 err
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int FRM_W = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam logic [MaxFramesPerCol-1:0] STRB_ONE = MaxFramesPerCol'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [FRM_W-1:0]   frame_idx;
    logic               match;
    logic [ROW_W-1:0]   row_cnt;
    logic [3:0]         strb_cnt;

    logic               xfer;
    logic               hdr_ok;
    logic               hdr_bad;
    logic               last_row;
    logic               last_strb;

    always_comb begin
        state_next = state;
        s_ready    = (state != STROBE);
        xfer       = s_valid && (state != STROBE);
        hdr_ok     = 1'b0;
        hdr_bad    = 1'b0;
        last_row   = (row_cnt == ROW_W'(NumRows - 1));
        last_strb  = (strb_cnt == 4'(StrobeCycles - 1));
        case (state)
            IDLE: begin
                if (xfer) begin
                    // Sync byte must match and the frame index must name a real strobe line.
                    if ((s_data[31:24] == 8'hA5) &&
                        ({24'd0, s_data[7:0]} < 32'(MaxFramesPerCol))) begin
                        hdr_ok     = 1'b1;
                        state_next = LOAD;
                    end else begin
                        hdr_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer && last_row) begin
                    state_next = match ? STROBE : IDLE;
                end
            end
            STROBE: begin
                if (last_strb) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            frame_idx   <= '0;
            match       <= 1'b0;
            row_cnt     <= '0;
            strb_cnt    <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);

            if (hdr_bad) begin
                err <= 1'b1;
            end

            if (hdr_ok) begin
                frame_idx <= s_data[FRM_W-1:0];
                match     <= (s_data[15:8] == 8'(ColumnIndex));
                row_cnt   <= '0;
            end

            if ((state == LOAD) && xfer) begin
                row_cnt <= row_cnt + 1'b1;
                if (match) begin
                    for (int r = 0; r < NumRows; r++) begin
                        if (row_cnt == ROW_W'(r)) begin
                            FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                        end
                    end
                end
            end

            // Strobe launches on the same edge that takes the last row so it
            // is visible immediately after the final data transfer.
            if ((state == LOAD) && (state_next == STROBE)) begin
                FrameStrobe <= STRB_ONE << frame_idx;
                strb_cnt    <= '0;
            end else if (state == STROBE) begin
                strb_cnt <= strb_cnt + 1'b1;
                if (last_strb) begin
                    FrameStrobe <= '0;
                end
            end
        end
    end

endmodule

// File: doc/frame_strobe_ctrl.md
# frame_strobe_ctrl

Per-column configuration frame loader that sits directly upstream of the fabric tiles' FrameStrobe and FrameData inputs. It accepts a word stream over a valid/ready handshake, parses a frame header, and collects one 32-bit data word per tile row into FrameData. When the header's column ID matches this column, it then drives a one-hot, fixed-length pulse on the addressed FrameStrobe line. That strobe enters the bottom of the column's FrameStrobe chain and is re-buffered tile to tile up to the N terminal tile.

## Interface
- MaxFramesPerCol, 36, number of FrameStrobe lines per column
- FrameBitsPerRow, 32, FrameData bits per tile row; also the stream word width
- NumRows, 16, tile rows fed by this column
- ColumnIndex, 0, 8-bit column ID this instance answers to
- StrobeCycles, 2, strobe pulse length in cycles; legal range 1..15

Ports:
- UserCLK  in  1  configuration/fabric clock; rising edge
- resetn  in  1  asynchronous, active-low reset
- s_data  in  FrameBitsPerRow  stream word
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts word; transfer = s_valid & s_ready at UserCLK rise
- FrameData  out  NumRows*FrameBitsPerRow  row r occupies [r*FrameBitsPerRow +: FrameBitsPerRow]
- FrameStrobe  out  MaxFramesPerCol  one-hot strobe, or all zero
- busy  out  1  high in LOAD and STROBE
- err  out  1  sticky header error; cleared only by reset

## Operation
- Header word fields: [31:24] sync, must be 8'hA5; [15:8] column ID; [7:0] frame index. Bits [23:16] are ignored.
- States: IDLE, LOAD, STROBE.
- IDLE: s_ready=1. On a transfer:
  - Bad header (sync != A5, or frame index >= MaxFramesPerCol): set err, drop the word, stay in IDLE.
  - Otherwise latch frame index, latch match = (col == ColumnIndex), clear row_cnt, go to LOAD.
- LOAD: s_ready=1. Each transfer is a data word for row row_cnt.
  - If match: write the word to FrameData row row_cnt. If not match: discard the word; FrameData is unchanged.
  - row_cnt increments per transfer. On the transfer with row_cnt == NumRows-1: go to STROBE if match, else go to IDLE.
  - Data words are never header-checked.
- STROBE: s_ready=0. FrameStrobe[frame] is high for exactly StrobeCycles cycles, counted by strb_cnt. Return to IDLE on the last strobe cycle.
- FrameData holds its value through STROBE and afterwards until the next matching LOAD.
- FrameStrobe is all zero outside STROBE. At most one bit is ever high.
- All outputs are registered, except s_ready, which is decoded from state.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-LOAD or mid-STROBE) values:
  - state=IDLE, FrameData=0, FrameStrobe=0, err=0, busy=0, s_ready=1.
  - Internal counters are also cleared.
- FrameData row r updates on the UserCLK edge that accepts data word r.
- FrameStrobe rises on the edge that accepts the last data word, so it is visible the cycle after that transfer. It falls StrobeCycles cycles later.
- s_ready goes low in the same cycle FrameStrobe rises. s_ready is high again in the cycle after FrameStrobe falls, so a header can be accepted then.
- Minimum frame period: 1 + NumRows + StrobeCycles cycles with s_valid held high.
- Gaps in s_valid stall LOAD indefinitely; there is no timeout.
- Column mismatch: busy drops the cycle after the last data word; no strobe cycles occur.
- A bad header never changes FrameData, FrameStrobe or state. Only err changes.

## Test plan
- Matching frame: send header 0xA5000005 (ColumnIndex=0), then 16 words 0x1000_0000+r.
  - FrameData row r = 0x1000_0000+r.
  - FrameStrobe = 1<<5 for exactly 2 cycles, beginning the cycle after the 16th transfer.
  - s_ready=0 during those 2 cycles.
- Column mismatch: send header 0xA5000307, then 16 words.
  - All 17 words are accepted.
  - FrameData is unchanged from the previous frame; FrameStrobe stays 0; busy falls after the last word.
- Bad headers: send 0x5A000001, then 0xA5000024 (frame 36).
  - Both are dropped; err=1 and stays 1.
  - A following valid frame still loads and strobes normally.
- Backpressure/stall: toggle s_valid randomly during LOAD and hold s_valid=1 during STROBE.
  - No word is lost or duplicated; row ordering is preserved.
  - No transfer occurs while s_ready=0.
- Reset mid-operation: assert resetn=0 after 7 data words, and separately during a strobe cycle.
  - FrameStrobe=0 and FrameData=0 immediately (asynchronously); state=IDLE.
  - A fresh frame after release works normally.
- Back-to-back frames to frames 0 and 35 with s_valid held high.
  - Frame period is 19 cycles.
  - The strobes are one-hot and never overlap.
